// File: rtl/alu.sv
// 8-bit ALU: combinational add/subtract plus sequential Booth radix-2 signed
// multiply and restoring unsigned divide, all behind one 16-bit result bus.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-low reset
//   BEGIN   start request for MUL/DIV, sampled in IDLE
//   Op      00 ADD, 01 SUB, 10 MUL, 11 DIV
//   inA     multiplicand (MUL) / dividend (DIV) / first operand (ADD/SUB)
//   inM     multiplier (MUL) / divisor (DIV) / second operand (ADD/SUB)
//   END     one-cycle completion pulse for MUL/DIV
//   OUTBUS  16-bit result
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        BEGIN,
    input  logic [1:0]  Op,
    input  logic [7:0]  inA,
    input  logic [7:0]  inM,
    output logic        END,
    output logic [15:0] OUTBUS
);

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q;      // Booth accumulator / division remainder
    logic [7:0]  q_q;      // multiplier / dividend-then-quotient
    logic        qm1_q;    // Booth Q-1 bit
    logic [7:0]  m_q;      // multiplicand / divisor
    logic [2:0]  cnt_q;
    logic        div_q;    // latched Op[0]: 1 = divide
    logic [15:0] res_q;

    logic [9:0]  alu_x, alu_y, alu_r;
    logic        alu_sub;
    logic [1:0]  booth;
    logic [8:0]  mul_a_ext;
    logic [7:0]  a_it, q_it;
    logic        qm1_it;
    logic [15:0] addsub;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (BEGIN && Op[1]) state_d = StLoad;
            StLoad:  state_d = StIter;
            StIter:  if (cnt_q == 3'd7) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shared add/subtract unit and per-iteration update
    always_comb begin
        booth = {q_q[0], qm1_q};
        if (div_q) begin
            // Shifted remainder is 9 bits wide: with divisor > 128 it can exceed 255.
            alu_x   = {1'b0, a_q, q_q[7]};
            alu_y   = {2'b00, m_q};
            alu_sub = 1'b1;
        end else begin
            // Sign-extended to 9+ bits so A +/- M cannot overflow before the shift.
            alu_x   = {{2{a_q[7]}}, a_q};
            alu_y   = {{2{m_q[7]}}, m_q};
            alu_sub = (booth == 2'b10);
        end
        alu_r = alu_sub ? (alu_x - alu_y) : (alu_x + alu_y);

        mul_a_ext = (booth == 2'b01 || booth == 2'b10) ? alu_r[8:0] : {a_q[7], a_q};

        if (div_q) begin
            // alu_r[9] set means the trial subtraction went negative: restore.
            a_it   = alu_r[9] ? {a_q[6:0], q_q[7]} : alu_r[7:0];
            q_it   = {q_q[6:0], ~alu_r[9]};
            qm1_it = qm1_q;
        end else begin
            a_it   = mul_a_ext[8:1];
            q_it   = {mul_a_ext[0], q_q[7:1]};
            qm1_it = q_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= 8'd0;
            q_q     <= 8'd0;
            qm1_q   <= 1'b0;
            m_q     <= 8'd0;
            cnt_q   <= 3'd0;
            div_q   <= 1'b0;
            res_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StLoad: begin
                    a_q   <= 8'd0;
                    qm1_q <= 1'b0;
                    cnt_q <= 3'd0;
                    div_q <= Op[0];
                    if (Op[0]) begin
                        q_q <= inA;
                        m_q <= inM;
                    end else begin
                        q_q <= inM;
                        m_q <= inA;
                    end
                end
                StIter: begin
                    a_q   <= a_it;
                    q_q   <= q_it;
                    qm1_q <= qm1_it;
                    cnt_q <= cnt_q + 3'd1;
                end
                StDone:  res_q <= {a_q, q_q};
                default: ;
            endcase
        end
    end

    assign addsub = Op[0] ? ({8'd0, inA} - {8'd0, inM}) : ({8'd0, inA} + {8'd0, inM});
    assign END    = (state_q == StDone);
    assign OUTBUS = (state_q == StIdle && !Op[1]) ? addsub : res_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: expected results go into a scoreboard queue when
// stimulus is applied and are popped when the DUT result is due.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        BEGIN;
    logic [1:0]  Op;
    logic [7:0]  inA;
    logic [7:0]  inM;
    logic        END;
    logic [15:0] OUTBUS;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_res;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .BEGIN  (BEGIN),
        .Op     (Op),
        .inA    (inA),
        .inM    (inM),
        .END    (END),
        .OUTBUS (OUTBUS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] m);
        logic signed [15:0] p;
        case (op)
            2'b00: model = {8'd0, a} + {8'd0, m};
            2'b01: model = {8'd0, a} - {8'd0, m};
            2'b10: begin
                p = $signed({{8{a[7]}}, a}) * $signed({{8{m[7]}}, m});
                model = p;
            end
            default: model = (m == 8'd0) ? {a, 8'hFF} : {a % m, a / m};
        endcase
    endfunction

    task automatic comb_check(input string tag, input logic [1:0] op, input logic [7:0] a,
                              input logic [7:0] m);
        logic [15:0] e;
        Op  = op;
        inA = a;
        inM = m;
        exp_q.push_back(model(op, a, m));
        #1;
        e = exp_q.pop_front();
        check(tag, OUTBUS, e);
    endtask

    // Runs one MUL/DIV; with corrupt set, inputs and BEGIN are disturbed mid-ITER.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] m, input bit corrupt);
        int lat;
        int extra;
        logic [15:0] e;
        @(negedge clk);
        Op    = op;
        inA   = a;
        inM   = m;
        BEGIN = 1'b1;
        exp_q.push_back(model(op, a, m));
        @(posedge clk);
        #1;
        BEGIN = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (corrupt && k == 3) begin
                inA   = 8'hA5;
                inM   = 8'h5A;
                Op    = ~op;
                BEGIN = 1'b1;
            end
            if (corrupt && k == 4) BEGIN = 1'b0;
            if (k == 5) check({tag, "_hold"}, OUTBUS, last_res);
            if (END) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 16'(lat), 16'd9);
        @(posedge clk);
        #1;
        check({tag, "_end_width"}, {15'd0, END}, 16'd0);
        if (corrupt) Op = op;
        #1;
        e = exp_q.pop_front();
        check({tag, "_result"}, OUTBUS, e);
        last_res = e;
        if (corrupt) begin
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk);
                #1;
                if (END) extra++;
            end
            check({tag, "_extra_end"}, 16'(extra), 16'd0);
        end
    endtask

    initial begin
        int endcnt;
        rst      = 1'b0;
        BEGIN    = 1'b0;
        Op       = 2'b10;
        inA      = 8'd0;
        inM      = 8'd0;
        last_res = 16'd0;
        #1;
        check("rst_outbus", OUTBUS, 16'd0);
        check("rst_end", {15'd0, END}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_outbus", OUTBUS, 16'd0);

        comb_check("add_27_20", 2'b00, 8'd27, 8'd20);
        comb_check("add_carry", 2'b00, 8'd255, 8'd255);
        comb_check("sub_40_33", 2'b01, 8'd40, 8'd33);
        comb_check("sub_3_5", 2'b01, 8'd3, 8'd5);

        run_op("mul_15x3", 2'b10, 8'd15, 8'd3, 1'b0);
        run_op("mul_m5x7", 2'b10, 8'hFB, 8'd7, 1'b0);
        run_op("mul_neg_neg", 2'b10, 8'hF6, 8'hF3, 1'b0);
        run_op("div_100_3", 2'b11, 8'd100, 8'd3, 1'b0);
        run_op("div_200_0", 2'b11, 8'd200, 8'd0, 1'b0);
        run_op("div_255_200", 2'b11, 8'd255, 8'd200, 1'b0);
        run_op("mul_corrupt", 2'b10, 8'd15, 8'd3, 1'b1);

        // Reset during DIV iteration 4
        @(negedge clk);
        Op    = 2'b11;
        inA   = 8'd100;
        inM   = 8'd3;
        BEGIN = 1'b1;
        @(posedge clk);
        #1;
        BEGIN = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_end", {15'd0, END}, 16'd0);
        check("abort_outbus", OUTBUS, 16'd0);
        endcnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (END) endcnt++;
        end
        check("abort_no_end", 16'(endcnt), 16'd0);
        check("abort_idle_outbus", OUTBUS, 16'd0);
        last_res = 16'd0;
        run_op("div_after_abort", 2'b11, 8'd100, 8'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu.md
# alu

Eight-bit arithmetic unit providing add, subtract, signed multiply and unsigned divide behind a single 16-bit result bus. Add and subtract are combinational. Multiply (Booth radix-2) and divide (restoring) are sequential: a control FSM steps a shared datapath of registers, an 8-bit add/subtract unit, a mux and an iteration counter. The block is a leaf datapath used as the project's top-level ALU.

## Interface
- No parameters; operand width is fixed at 8 bits and the result at 16 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state while low.
- BEGIN  in  1  start request for multiply/divide; sampled on the rising edge in IDLE.
- Op  in  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- inA  in  8  operand A (multiplicand for MUL, dividend for DIV).
- inM  in  8  operand M (multiplier for MUL, divisor for DIV).
- END  out  1  one-cycle completion pulse for MUL/DIV.
- OUTBUS  out  16  result bus.

## Operation
- ADD (Op=00): OUTBUS = {7'b0, carry, sum} = zero-extended inA + inM; combinational; FSM unaffected.
- SUB (Op=01): OUTBUS = 16-bit two's-complement of zero-extended inA − inM (40−33 → 7; 3−5 → 0xFFFE); combinational.
- ADD/SUB output is shown whenever Op[1]=0 and the FSM is in IDLE. Otherwise OUTBUS shows the result register.
- MUL (Op=10): signed 8×8 → 16-bit two's-complement product.
  - Booth radix-2 uses registers A(8), Q(8), Q−1(1) and M(8).
  - Each iteration examines {Q[0],Q−1}: 01 → A+=M; 10 → A−=M; otherwise no change. Then {A,Q,Q−1} is shifted arithmetic-right by 1.
  - Result = {A,Q}.
- DIV (Op=11): unsigned restoring division.
  - Each iteration shifts {R,Q} left by 1, then computes R−M.
  - If the difference is non-negative: keep it and set Q[0]=1. Otherwise: restore R and set Q[0]=0.
  - Result OUTBUS = {remainder, quotient} (100/3 → quotient 33 in [7:0], remainder 1 in [15:8]).
  - Divide by zero: quotient 0xFF, remainder = inA. No error flag.
- FSM states:
  - IDLE: waits for BEGIN=1 with Op[1]=1, then goes to LOAD.
  - LOAD: latches Op, inA and inM; clears A/R, Q−1 and the counter.
  - ITER: 8 iterations, one per cycle; the counter increments each cycle.
  - DONE: writes the result register, asserts END, returns to IDLE.
- Operands and Op are latched in LOAD. Input changes during ITER/DONE are ignored.
- BEGIN while busy is ignored. If BEGIN is still high in IDLE after DONE, a new operation starts; this is not an error.
- BEGIN with Op[1]=0 is ignored by the FSM.

## Timing
- Reset (rst=0, asynchronous): FSM→IDLE; result register, A/Q/M, counter → 0; END=0.
  - OUTBUS then shows the combinational ADD/SUB value for the current inputs, or 0 if Op[1]=1.
- Reset mid-operation aborts the operation immediately; no END pulse is produced.
- MUL/DIV latency, with edge 0 being the edge that samples BEGIN:
  - LOAD at edge 1; ITER edges 2–9; DONE state after edge 9.
  - END is high for exactly one cycle, between edges 9 and 10.
  - OUTBUS holds the new result from edge 10 onward.
  - Total: 10 cycles from sampling BEGIN to the result being stable.
- ADD/SUB: valid within the combinational settle time of an input change; no clock required.
- During ITER, OUTBUS holds the previous MUL/DIV result. It never shows partial products.

## Test plan
- Reset low, then release; Op=10 → OUTBUS=0, END=0. Op=00, inA=27, inM=20 with no clock activity required → OUTBUS=47.
- Op=01, inA=40, inM=33 → OUTBUS=7. Then inA=3, inM=5 → OUTBUS=0xFFFE.
- Op=10, inA=15, inM=3, BEGIN pulsed for one cycle → END pulses once, 10 cycles later; OUTBUS=45. Also inA=0xFB (−5), inM=7 → OUTBUS=0xFFDD (−35).
- Op=11, inA=100, inM=3 → after END: OUTBUS[7:0]=33, OUTBUS[15:8]=1. Then inA=200, inM=0 → quotient 0xFF, remainder 200.
- Start MUL (15×3); change inA/inM/Op mid-ITER and toggle BEGIN → result still 45, exactly one END pulse.
- Start DIV; assert rst low at ITER cycle 4 → END stays 0, OUTBUS goes to 0 while Op=11, FSM returns to IDLE. After release, a new DIV (100/3) completes correctly.
